alu_seq_unit: RTL and testbench
===============================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be even and >= 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid_in  input  1  operation request, sampled each clk edge.
REQ-005 alu_op  input  2  main-decoder class: 0 add, 1 sub, 2 R-type (use func_code), 3 LUI.
REQ-006 func_code  input  6  R-type function field.
REQ-007 a  input  WIDTH  operand A (rs).
REQ-008 b  input  WIDTH  operand B (rt/imm).
REQ-009 result  output  WIDTH  registered result of last completed op.
REQ-010 zero  output  1  registered; high when result == 0.
REQ-011 done  output  1  one-cycle pulse on completion of an op.
REQ-012 busy  output  1  high while an iterative op is in progress.
REQ-013 hi, lo  output  WIDTH each  HI/LO registers.
REQ-014 illegal  output  1  registered; high with done for an undefined func_code.
REQ-015 div_by_zero  output  1  registered; high with done for DIV/DIVU with b == 0.

Function
REQ-016 Control code decode SHALL be: alu_op 0 -> ADD, 1 -> SUB, 3 -> LUI (b << WIDTH/2); alu_op 2 by func_code: 32 ADD, 34 SUB, 36 AND, 37 OR, 39 NOR, 42 SLT (signed), 43 SLTU, 38 XOR, 24 MULT, 25 MULTU, 26 DIV, 27 DIVU, 16 MFHI, 18 MFLO; any other -> illegal.
REQ-017 Request SHALL be accepted when valid_in && !busy; requests while busy SHALL be ignored with no state change.
REQ-018 Single-cycle ops (all except MULT/MULTU/DIV/DIVU) SHALL update result and zero and pulse done on the edge after acceptance (latency 1); hi/lo unchanged.
REQ-019 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-020 SLT/SLTU SHALL output 1 or 0 zero-extended to WIDTH.
REQ-021 Illegal func_code SHALL set result = 0, illegal = 1, done pulse at latency 1; hi/lo unchanged.
REQ-022 FSM states IDLE, MUL, DIV, FIN; IDLE -> MUL/DIV on accepted iterative op; MUL/DIV SHALL run exactly WIDTH iteration cycles, then FIN; FIN -> IDLE with done pulse; total latency WIDTH+1 cycles.
REQ-023 busy SHALL be high from the edge after acceptance through the FIN cycle inclusive, low in IDLE.
REQ-024 MULT/MULTU: shift-add, one bit per cycle on operand magnitudes; signed product sign-corrected in FIN; {hi,lo} = full 2*WIDTH product.
REQ-025 DIV/DIVU: restoring, one quotient bit per cycle; lo = quotient, hi = remainder; signed: quotient truncates toward zero, remainder takes dividend sign.
REQ-026 Signed most-negative / -1 SHALL give lo = most-negative value, hi = 0, no flag.
REQ-027 Divide by zero SHALL skip iteration: IDLE -> FIN, lo = all ones, hi = a, div_by_zero = 1, done at latency 2.
REQ-028 On iterative completion result SHALL be set to lo, zero reflects lo.
REQ-029 illegal and div_by_zero SHALL clear on the next accepted request.
REQ-030 MFHI/MFLO SHALL read hi/lo as held at acceptance.

Reset
REQ-031 Reset SHALL force state IDLE and result, hi, lo = 0; zero = 1; done, busy, illegal, div_by_zero = 0.
REQ-032 Reset during MUL/DIV SHALL abort the op with no done pulse and hi/lo cleared; reset dominates valid_in on the same edge.

Structure
REQ-033 Shared package alu_pkg SHALL hold the control-code enumeration (AND 0, OR 1, ADD 2, SUB 6, SLT 7, SLTU 8, XOR 9, NOR 12, LUI 13, MULT 3, MULTU 4, DIV 5, DIVU 10, MFHI 11, MFLO 14, ILLEGAL 15), func_code constants and FSM state type.
REQ-034 Decode SHALL be a sub-module alu_decode (alu_op, func_code -> 4-bit code); FSM, datapath and hi/lo live in alu_seq_unit.

Verification (WIDTH = 32)
REQ-035 alu_op 2, func 42, a = 0xFFFFFFFF, b = 1 -> next cycle result 1, zero 0, done pulse; func 43 same operands -> result 0, zero 1.
REQ-036 MULT a = 0xFFFFFFFD (-3), b = 7 -> busy 33 cycles, done at cycle 33, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, result = lo.
REQ-037 DIV a = -7, b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU a = 7, b = 0 -> done at cycle 2, div_by_zero 1, lo = 0xFFFFFFFF, hi = 7.
REQ-038 Second valid_in during MULTU busy -> ignored; hi/lo reflect first op only; exactly one done.
REQ-039 Reset asserted at cycle 10 of DIV -> no done, busy 0, hi = lo = 0 next cycle; new ADD 2+3 accepted after -> result 5.
REQ-040 alu_op 2, func 0x3F -> illegal 1, result 0, done at latency 1; following MFLO -> illegal 0, result = lo.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: control codes, MIPS function
// field values and the iterative-op state machine encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        CTRL_AND     = 4'd0,
        CTRL_OR      = 4'd1,
        CTRL_ADD     = 4'd2,
        CTRL_MULT    = 4'd3,
        CTRL_MULTU   = 4'd4,
        CTRL_DIV     = 4'd5,
        CTRL_SUB     = 4'd6,
        CTRL_SLT     = 4'd7,
        CTRL_SLTU    = 4'd8,
        CTRL_XOR     = 4'd9,
        CTRL_DIVU    = 4'd10,
        CTRL_MFHI    = 4'd11,
        CTRL_NOR     = 4'd12,
        CTRL_LUI     = 4'd13,
        CTRL_MFLO    = 4'd14,
        CTRL_ILLEGAL = 4'd15
    } ctrl_t;

    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_XOR   = 6'd38;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLTU  = 6'd43;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    function automatic logic is_iterative(input ctrl_t c);
        return (c == CTRL_MULT) || (c == CTRL_MULTU) || (c == CTRL_DIV) || (c == CTRL_DIVU);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Main-decoder class plus R-type function field to 4-bit ALU control code.
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] func_code,
    output ctrl_t      code
);

    always_comb begin
        code = CTRL_ILLEGAL;
        case (alu_op)
            2'd0: code = CTRL_ADD;
            2'd1: code = CTRL_SUB;
            2'd3: code = CTRL_LUI;
            default: begin
                case (func_code)
                    FN_ADD:   code = CTRL_ADD;
                    FN_SUB:   code = CTRL_SUB;
                    FN_AND:   code = CTRL_AND;
                    FN_OR:    code = CTRL_OR;
                    FN_NOR:   code = CTRL_NOR;
                    FN_SLT:   code = CTRL_SLT;
                    FN_SLTU:  code = CTRL_SLTU;
                    FN_XOR:   code = CTRL_XOR;
                    FN_MULT:  code = CTRL_MULT;
                    FN_MULTU: code = CTRL_MULTU;
                    FN_DIV:   code = CTRL_DIV;
                    FN_DIVU:  code = CTRL_DIVU;
                    FN_MFHI:  code = CTRL_MFHI;
                    FN_MFLO:  code = CTRL_MFLO;
                    default:  code = CTRL_ILLEGAL;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Single-cycle ALU with an iterative shift-add multiplier and restoring divider
// sharing one accumulator pair; results land in result and the HI/LO registers.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             illegal,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    ctrl_t              code;
    state_t             state, next_state;
    logic               accept, signed_op, div_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, alu_out;
    logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
    logic [CNT_W-1:0]   iter_cnt;
    logic               neg_lo, neg_hi, op_div, dbz_pend;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    alu_decode u_decode (
        .alu_op    (alu_op),
        .func_code (func_code),
        .code      (code)
    );

    assign busy      = (state != ST_IDLE);
    assign accept    = valid_in && !busy;
    assign signed_op = (code == CTRL_MULT) || (code == CTRL_DIV);
    assign div_op    = (code == CTRL_DIV) || (code == CTRL_DIVU);
    assign a_neg     = signed_op && a[WIDTH-1];
    assign b_neg     = signed_op && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    always_comb begin
        alu_out = '0;
        case (code)
            CTRL_ADD:  alu_out = a + b;
            CTRL_SUB:  alu_out = a - b;
            CTRL_AND:  alu_out = a & b;
            CTRL_OR:   alu_out = a | b;
            CTRL_XOR:  alu_out = a ^ b;
            CTRL_NOR:  alu_out = ~(a | b);
            CTRL_SLT:  alu_out = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            CTRL_SLTU: alu_out = {{(WIDTH-1){1'b0}}, a < b};
            CTRL_LUI:  alu_out = b << (WIDTH/2);
            CTRL_MFHI: alu_out = hi;
            CTRL_MFLO: alu_out = lo;
            default:   alu_out = '0;
        endcase
    end

    // One multiply step adds the multiplicand into the upper half and shifts
    // the product right; one divide step shifts a dividend bit into the remainder.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    assign prod_fix = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign fin_lo   = op_div ? (neg_lo ? -acc_lo : acc_lo) : prod_fix[WIDTH-1:0];
    assign fin_hi   = op_div ? (neg_hi ? -acc_hi : acc_hi) : prod_fix[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept && is_iterative(code)) begin
                    if (div_op && (b == '0)) next_state = ST_FIN;
                    else if (div_op)         next_state = ST_DIV;
                    else                     next_state = ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                if (iter_cnt == CNT_W'(WIDTH-1)) next_state = ST_FIN;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result      <= '0;
            zero        <= 1'b1;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            illegal     <= 1'b0;
            div_by_zero <= 1'b0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            iter_cnt    <= '0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            op_div      <= 1'b0;
            dbz_pend    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        illegal     <= (code == CTRL_ILLEGAL);
                        div_by_zero <= 1'b0;
                        iter_cnt    <= '0;
                        op_div      <= div_op;
                        dbz_pend    <= 1'b0;
                        if (!is_iterative(code)) begin
                            result <= alu_out;
                            zero   <= (alu_out == '0);
                            done   <= 1'b1;
                        end else if (div_op && (b == '0)) begin
                            // Preloading the accumulators lets the normal FIN path
                            // publish hi = a, lo = all ones.
                            acc_hi   <= a;
                            acc_lo   <= '1;
                            neg_lo   <= 1'b0;
                            neg_hi   <= 1'b0;
                            dbz_pend <= 1'b1;
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= div_op ? a_mag : b_mag;
                            opnd   <= div_op ? b_mag : a_mag;
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg;
                        end
                    end
                end
                ST_MUL: begin
                    acc_hi   <= mul_sum[WIDTH:1];
                    acc_lo   <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    iter_cnt <= iter_cnt + CNT_W'(1);
                end
                ST_DIV: begin
                    if (!div_diff[WIDTH]) begin
                        acc_hi <= div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    iter_cnt <= iter_cnt + CNT_W'(1);
                end
                default: begin
                    hi          <= fin_hi;
                    lo          <= fin_lo;
                    result      <= fin_lo;
                    zero        <= (fin_lo == '0);
                    div_by_zero <= dbz_pend;
                    done        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomised and directed checks of alu_seq_unit against an arithmetic model
// that tracks HI/LO and expected completion timing.
module tb_alu_seq_unit;

    localparam int W     = 32;
    localparam int LIMIT = W + 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [1:0]    alu_op;
    logic [5:0]    func_code;
    logic [W-1:0]  a, b;
    logic [W-1:0]  result, hi, lo;
    logic          zero, done, busy, illegal, div_by_zero;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  m_hi = '0;
    logic [W-1:0]  m_lo = '0;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .alu_op      (alu_op),
        .func_code   (func_code),
        .a           (a),
        .b           (b),
        .result      (result),
        .zero        (zero),
        .done        (done),
        .busy        (busy),
        .hi          (hi),
        .lo          (lo),
        .illegal     (illegal),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model: plain 64-bit arithmetic, updates the model HI/LO.
    // Latency counts negedge samples after the accepting edge until done.
    task automatic model(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic ill, output logic dbz, output int lat, output int bsy);
        longint sx, sy, q, rm;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = '0; ill = 1'b0; dbz = 1'b0; lat = 1; bsy = 0;
        if (op == 2'd0)      r = x + y;
        else if (op == 2'd1) r = x - y;
        else if (op == 2'd3) r = y << (W/2);
        else begin
            case (fn)
                6'd32: r = x + y;
                6'd34: r = x - y;
                6'd36: r = x & y;
                6'd37: r = x | y;
                6'd38: r = x ^ y;
                6'd39: r = ~(x | y);
                6'd42: r = (sx < sy) ? 1 : 0;
                6'd43: r = (x < y) ? 1 : 0;
                6'd16: r = m_hi;
                6'd18: r = m_lo;
                6'd24, 6'd25: begin
                    if (fn == 6'd24) p = 64'(sx * sy);
                    else             p = 64'(x) * 64'(y);
                    m_hi = p[63:32]; m_lo = p[31:0];
                    r = m_lo; lat = W + 2; bsy = W + 1;
                end
                6'd26, 6'd27: begin
                    if (y == '0) begin
                        m_hi = x; m_lo = '1; dbz = 1'b1; lat = 2; bsy = 1;
                    end else begin
                        if (fn == 6'd26) begin
                            q = sx / sy; rm = sx % sy;
                        end else begin
                            q = longint'(x) / longint'(y); rm = longint'(x) % longint'(y);
                        end
                        m_lo = q[31:0]; m_hi = rm[31:0];
                        lat = W + 2; bsy = W + 1;
                    end
                    r = m_lo;
                end
                default: ill = 1'b1;
            endcase
        end
    endtask

    // Presents one request for a single clock, then watches for done.
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output int lat, output int bc);
        @(negedge clk);
        valid_in = 1'b1; alu_op = op; func_code = fn; a = x; b = y;
        @(negedge clk);
        valid_in = 1'b0;
        lat = 0; bc = 0;
        for (int i = 1; i <= LIMIT; i++) begin
            if (busy) bc++;
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic runOp(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic ill, dbz;
        int elat, ebsy, lat, bc;
        model(op, fn, x, y, r, ill, dbz, elat, ebsy);
        applyStimulus(op, fn, x, y, lat, bc);
        checkOutput("latency", lat, elat);
        checkOutput("busy_cycles", bc, ebsy);
        checkOutput("result", result, r);
        checkOutput("zero", zero, r == '0);
        checkOutput("hi", hi, m_hi);
        checkOutput("lo", lo, m_lo);
        checkOutput("illegal", illegal, ill);
        checkOutput("div_by_zero", div_by_zero, dbz);
        @(negedge clk);
        checkOutput("done_pulse_width", done, 1'b0);
    endtask

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [5:0] fn_list [14] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42,
                                     6'd43, 6'd24, 6'd25, 6'd26, 6'd27, 6'd16, 6'd18};
        logic [W-1:0] r;
        logic ill, dbz;
        int elat, ebsy, done_cnt;

        reset = 1'b1; valid_in = 1'b0; alu_op = '0; func_code = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_zero", zero, 1);
        checkOutput("reset_hi_lo", {hi, lo}, 0);
        checkOutput("reset_flags", {done, busy, illegal, div_by_zero}, 0);
        reset = 1'b0;

        // SLT vs SLTU on the same operands
        runOp(2'd2, 6'd42, 32'hFFFF_FFFF, 32'd1);
        checkOutput("slt_literal", result, 1);
        runOp(2'd2, 6'd43, 32'hFFFF_FFFF, 32'd1);
        checkOutput("sltu_literal", {result, zero}, {32'd0, 1'b1});

        runOp(2'd2, 6'd24, 32'hFFFF_FFFD, 32'd7);
        checkOutput("mult_literal", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        runOp(2'd2, 6'd26, -32'sd7, 32'd2);
        checkOutput("div_literal", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        runOp(2'd2, 6'd27, 32'd7, 32'd0);
        checkOutput("divz_literal", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        runOp(2'd2, 6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("minneg_literal", {hi, lo, div_by_zero}, {32'd0, 32'h8000_0000, 1'b0});
        runOp(2'd2, 6'd63, 32'd5, 32'd9);
        runOp(2'd2, 6'd18, 32'd0, 32'd0);
        runOp(2'd3, 6'd0, 32'd1, 32'h0000_ABCD);

        // A request raised while MULTU is busy must be ignored
        model(2'd2, 6'd25, 32'd123456, 32'd654321, r, ill, dbz, elat, ebsy);
        @(negedge clk);
        valid_in = 1'b1; alu_op = 2'd2; func_code = 6'd25; a = 32'd123456; b = 32'd654321;
        @(negedge clk);
        valid_in = 1'b0;
        done_cnt = 0;
        for (int i = 1; i <= W + 6; i++) begin
            if (done) done_cnt++;
            if (i == 3) begin
                valid_in = 1'b1; alu_op = 2'd2; func_code = 6'd32; a = 32'd1; b = 32'd1;
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("overlap_done_count", done_cnt, 1);
        checkOutput("overlap_hi_lo", {hi, lo}, {m_hi, m_lo});
        checkOutput("overlap_result", result, r);

        // Reset in the middle of a DIV aborts it
        @(negedge clk);
        valid_in = 1'b1; alu_op = 2'd2; func_code = 6'd26; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy_done", {busy, done}, 0);
        checkOutput("abort_hi_lo", {hi, lo}, 0);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        checkOutput("abort_no_late_done", done, 0);
        runOp(2'd0, 6'd0, 32'd2, 32'd3);
        checkOutput("post_reset_add", result, 5);

        for (int n = 0; n < 60; n++) begin
            logic [1:0] op;
            logic [5:0] fn;
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom);
            if (op == 2'd2 && $urandom_range(0, 7) != 0) fn = fn_list[$urandom_range(0, 13)];
            runOp(op, fn, pickOperand(), pickOperand());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
